// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters. Each operation runs IDLE -> EXEC -> RESP.
// Build option ALU_ARB_FIXED_PRIO_EN replaces round-robin arbitration with fixed r0-first priority.
module alu_share_arbiter #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          r0_valid,
   input  logic          r1_valid,
   output logic          r0_ready,
   output logic          r1_ready,
   input  logic [DW-1:0] r0_a,
   input  logic [DW-1:0] r0_b,
   input  logic [DW-1:0] r1_a,
   input  logic [DW-1:0] r1_b,
   input  logic [2:0]    r0_aluop,
   input  logic [2:0]    r1_aluop,
   input  logic [2:0]    r0_funct3,
   input  logic [2:0]    r1_funct3,
   output logic          r0_rsp_valid,
   output logic          r1_rsp_valid,
   input  logic          r0_rsp_ready,
   input  logic          r1_rsp_ready,
   output logic [DW-1:0] rsp_result,
   output logic          rsp_zero,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [2:0]    alu_aluop,
   output logic [2:0]    alu_funct3,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_zero,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state, state_nxt;
   logic          owner;
   logic          grant;
   logic          accept;
   logic          rsp_fire;
   logic [DW-1:0] a_q, b_q, result_q;
   logic [2:0]    aluop_q, funct3_q;
   logic          zero_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign grant = r1_valid && !r0_valid;
`else
   logic rr_ptr;

   // rr_ptr only matters when both requesters contend.
   assign grant = (r0_valid && r1_valid) ? rr_ptr : r1_valid;

   always_ff @(posedge clk) begin
      if (!rst_n)
         rr_ptr <= 1'b0;
      else if (accept)
         rr_ptr <= ~grant;
   end
`endif

   // Handshake outputs are gated by rst_n so they read 0 during the reset cycle itself.
   assign accept       = rst_n && (state == IDLE) && (r0_valid || r1_valid);
   assign r0_ready     = accept && !grant;
   assign r1_ready     = accept && grant;
   assign rsp_fire     = (state == RESP) && (owner ? r1_rsp_ready : r0_rsp_ready);
   assign r0_rsp_valid = rst_n && (state == RESP) && !owner;
   assign r1_rsp_valid = rst_n && (state == RESP) && owner;
   assign busy         = rst_n && (state != IDLE);

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_aluop  = aluop_q;
   assign alu_funct3 = funct3_q;
   assign rsp_result = result_q;
   assign rsp_zero   = zero_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         aluop_q  <= '0;
         funct3_q <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner    <= grant;
            a_q      <= grant ? r1_a      : r0_a;
            b_q      <= grant ? r1_b      : r0_b;
            aluop_q  <= grant ? r1_aluop  : r0_aluop;
            funct3_q <= grant ? r1_funct3 : r0_funct3;
         end
         if (state == EXEC) begin
            result_q <= alu_result;
            zero_q   <= alu_zero;
         end
      end
   end

endmodule
